// File: rtl/phase_seq_fsm_pkg.sv
// Shared encodings and limits for the phase sequencer: state codes, error codes
// and the legal parameter ranges.
package phase_seq_fsm_pkg;

    localparam int STEPS_MIN = 2;
    localparam int STEPS_MAX = 8;
    localparam int RECOV_MIN = 1;
    localparam int RECOV_MAX = 15;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_ERROR = 4'd1,
        ST_PH0   = 4'd2,
        ST_PH1   = 4'd3,
        ST_PH2   = 4'd4,
        ST_PH3   = 4'd5,
        ST_PH4   = 4'd6,
        ST_PH5   = 4'd7,
        ST_PH6   = 4'd8,
        ST_PH7   = 4'd9
    } state_e;

    localparam logic [3:0] PH_BASE   = 4'd2;

    localparam logic [1:0] ERR_NONE  = 2'b00;
    localparam logic [1:0] ERR_PROTO = 2'b01;
    localparam logic [1:0] ERR_TMO   = 2'b10;

endpackage

// File: rtl/phase_seq_fsm_sat_cnt.sv
// Saturating up-counter with synchronous clear and load; used for the dwell,
// recovery and error-entry counts.
module sat_cnt #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         nrst,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         inc,
    output logic [W-1:0] q
);

    // Clear beats load beats increment; increment sticks at all-ones.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            q <= {W{1'b0}};
        end else if (clr) begin
            q <= {W{1'b0}};
        end else if (load) begin
            q <= load_val;
        end else if (inc && (q != {W{1'b1}})) begin
            q <= q + W'(1'b1);
        end else begin
            q <= q;
        end
    end

endmodule

// File: rtl/phase_seq_fsm.sv
// Multi-phase handshake sequencer: walks PH0..PH(STEPS-1) on alternating i2
// levels, with per-phase timeout, protocol checking and counted ERROR recovery.
module phase_seq_fsm
    import phase_seq_fsm_pkg::*;
#(
    parameter int STEPS = 2,
    parameter int TW    = 8,
    parameter int RECOV = 1,
    parameter int ECW   = 4
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             i1,
    input  logic             i2,
    input  logic [TW-1:0]    tmo_lim,
    input  logic             clr_err,
    output logic [STEPS-1:0] o_phase,
    output logic             done,
    output logic             err,
    output logic [1:0]       err_code,
    output logic [ECW-1:0]   err_cnt
);

    localparam logic [3:0]     LAST_K    = 4'(STEPS - 1);
    localparam logic [3:0]     REC_LAST  = 4'(RECOV - 1);
    localparam logic [TW-1:0]  DWELL_ONE = TW'(1'b1);
    localparam logic [ECW-1:0] CNT_ONE   = ECW'(1'b1);

    state_e           state_r, state_s;
    logic [STEPS-1:0] phase_r, phase_s;
    logic             done_r, done_s;
    logic             err_r;
    logic [1:0]       err_code_r, code_s;
    logic [3:0]       ph_k_s, nxt_k_s;
    logic             enter_err_s, enter_ph_s, dwell_inc_s, rec_inc_s;
    logic [TW-1:0]    dwell_q_s;
    logic [3:0]       rec_q_s;

    assign ph_k_s = state_r - PH_BASE;

    // Next-state and next-output decode for the current state.
    always_comb begin
        state_s     = state_r;
        done_s      = 1'b0;
        code_s      = ERR_NONE;
        enter_err_s = 1'b0;
        enter_ph_s  = 1'b0;
        dwell_inc_s = 1'b0;
        rec_inc_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (i1 && i2) begin
                    state_s    = ST_PH0;
                    enter_ph_s = 1'b1;
                end else if (i1) begin
                    state_s     = ST_ERROR;
                    code_s      = ERR_PROTO;
                    enter_err_s = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ERROR: begin
                code_s = err_code_r;
                if (i1) begin
                    state_s = ST_ERROR;
                end else if (rec_q_s == REC_LAST) begin
                    state_s = ST_IDLE;
                    code_s  = ERR_NONE;
                end else begin
                    rec_inc_s = 1'b1;
                end
            end
            ST_PH0, ST_PH1, ST_PH2, ST_PH3, ST_PH4, ST_PH5, ST_PH6, ST_PH7: begin
                // A toggle is examined before the timeout so it wins on the expiry cycle.
                if (ph_k_s > LAST_K) begin
                    state_s = ST_IDLE;
                end else if (i2 == ph_k_s[0]) begin
                    if ((tmo_lim != {TW{1'b0}}) && (dwell_q_s == tmo_lim)) begin
                        state_s     = ST_ERROR;
                        code_s      = ERR_TMO;
                        enter_err_s = 1'b1;
                    end else begin
                        dwell_inc_s = 1'b1;
                    end
                end else if (i1) begin
                    if (ph_k_s == LAST_K) begin
                        state_s = ST_IDLE;
                        done_s  = 1'b1;
                    end else begin
                        state_s    = state_e'(state_r + 4'd1);
                        enter_ph_s = 1'b1;
                    end
                end else begin
                    state_s     = ST_ERROR;
                    code_s      = ERR_PROTO;
                    enter_err_s = 1'b1;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    assign nxt_k_s = state_s - PH_BASE;

    // One-hot phase vector for the state being entered.
    always_comb begin
        phase_s = {STEPS{1'b0}};
        for (int j = 0; j < STEPS; j++) begin
            phase_s[j] = (state_s >= ST_PH0) && (nxt_k_s == 4'(j));
        end
    end

    // State and output registers, all updated on the same edge.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_r    <= ST_IDLE;
            phase_r    <= {STEPS{1'b0}};
            done_r     <= 1'b0;
            err_r      <= 1'b0;
            err_code_r <= ERR_NONE;
        end else begin
            state_r    <= state_s;
            phase_r    <= phase_s;
            done_r     <= done_s;
            err_r      <= (state_s == ST_ERROR);
            err_code_r <= code_s;
        end
    end

    sat_cnt #(.W(TW)) u_dwell (
        .clk      (clk),
        .nrst     (nrst),
        .clr      (~(enter_ph_s | dwell_inc_s)),
        .load     (enter_ph_s),
        .load_val (DWELL_ONE),
        .inc      (dwell_inc_s),
        .q        (dwell_q_s)
    );

    sat_cnt #(.W(4)) u_recov (
        .clk      (clk),
        .nrst     (nrst),
        .clr      (~rec_inc_s),
        .load     (1'b0),
        .load_val (4'd0),
        .inc      (rec_inc_s),
        .q        (rec_q_s)
    );

    // A clear landing with an error entry counts that entry.
    sat_cnt #(.W(ECW)) u_errcnt (
        .clk      (clk),
        .nrst     (nrst),
        .clr      (clr_err & ~enter_err_s),
        .load     (clr_err & enter_err_s),
        .load_val (CNT_ONE),
        .inc      (enter_err_s),
        .q        (err_cnt)
    );

    assign o_phase  = phase_r;
    assign done     = done_r;
    assign err      = err_r;
    assign err_code = err_code_r;

endmodule
